uart_cmd_responder: RTL and testbench

//  Knight-side end of the remote command link. It deserializes 8N1 UART bytes
//  on RX and pairs them, high byte first, into a 16-bit command, then flags
//  the command as ready. It also serializes a single 8-bit response byte
//  (e.g. 8'hA5 = done/ack) onto TX on request. Sits between the RX/TX pins
//  and the command processor inside KnightsTour.

---
 rtl/uart_cmd_responder_if.sv | 28 ++
 rtl/uart_cmd_responder.sv | 187 ++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_responder_if.sv
// Command/response handshake between the UART responder and the command processor.
// The responder owns the slave modport; the command processor owns master.
interface uart_cmd_responder_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        snd_resp;
    logic        resp_sent;

    modport master (
        input  cmd,
        input  cmd_rdy,
        input  resp_sent,
        output clr_cmd_rdy,
        output resp,
        output snd_resp
    );

    modport slave (
        output cmd,
        output cmd_rdy,
        output resp_sent,
        input  clr_cmd_rdy,
        input  resp,
        input  snd_resp
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Knight-side UART link: receives 8N1 byte pairs into a 16-bit command and
// transmits single-byte responses. RX and TX run independently (full duplex).
module uart_cmd_responder #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    output logic                 TX,
    uart_cmd_responder_if.slave  cmd_if
);

    localparam int unsigned     CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {ASM_HIGH, ASM_LOW}                   asm_state_t;
    typedef enum logic       {TX_IDLE, TX_SHIFT}                   tx_state_t;

    // ---------------------------------------------------------------- RX
    rx_state_t        rx_state, rx_next;
    logic             rx_ff1, rx_ff2, rx_prev;
    logic [CNT_W-1:0] rx_cnt;
    logic [3:0]       rx_bits;
    logic [7:0]       rx_shift;
    logic             start_det, rx_tick, rx_restart;
    logic             rx_begin, byte_ok, frame_err;

    // Preset to 1 so reset never looks like a falling edge on the idle line
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ff1  <= 1'b1;
            rx_ff2  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_ff1  <= RX;
            rx_ff2  <= rx_ff1;
            rx_prev <= rx_ff2;
        end
    end

    assign start_det = rx_prev & ~rx_ff2;
    assign rx_tick   = (rx_cnt == FULL);

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (start_det) rx_next = RX_START;
            RX_START: if (rx_cnt == HALF) rx_next = rx_ff2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bits == 4'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_begin   = (rx_state == RX_IDLE) && start_det;
        byte_ok    = (rx_state == RX_STOP) && rx_tick &&  rx_ff2;
        frame_err  = (rx_state == RX_STOP) && rx_tick && !rx_ff2;
        rx_restart = (rx_state == RX_IDLE) ||
                     ((rx_state == RX_START) ? (rx_cnt == HALF) : rx_tick);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
        end else begin
            rx_cnt <= rx_restart ? '0 : rx_cnt + CNT_W'(1);
            if (rx_state != RX_DATA) begin
                rx_bits <= '0;
            end else if (rx_tick) begin
                rx_bits  <= rx_bits + 4'd1;
                rx_shift <= {rx_ff2, rx_shift[7:1]};
            end
        end
    end

    // ---------------------------------------------------- command assembly
    asm_state_t  asm_state, asm_next;
    logic [7:0]  hi_byte;
    logic [15:0] cmd_q;
    logic        cmd_rdy_q;
    logic        load_hi, load_cmd, rdy_clr;

    always_ff @(posedge clk) begin
        if (rst) asm_state <= ASM_HIGH;
        else     asm_state <= asm_next;
    end

    always_comb begin
        asm_next = asm_state;
        unique case (asm_state)
            ASM_HIGH: if (byte_ok) asm_next = ASM_LOW;
            ASM_LOW:  if (byte_ok || frame_err) asm_next = ASM_HIGH;
            default:  asm_next = ASM_HIGH;
        endcase
    end

    always_comb begin
        load_hi  = (asm_state == ASM_HIGH) && byte_ok;
        load_cmd = (asm_state == ASM_LOW)  && byte_ok;
        rdy_clr  = cmd_if.clr_cmd_rdy || ((asm_state == ASM_HIGH) && rx_begin);
    end

    // Completion takes priority over any clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_byte   <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            if (load_hi) hi_byte <= rx_shift;
            if (load_cmd) begin
                cmd_q     <= {hi_byte, rx_shift};
                cmd_rdy_q <= 1'b1;
            end else if (rdy_clr) begin
                cmd_rdy_q <= 1'b0;
            end
        end
    end

    assign cmd_if.cmd     = cmd_q;
    assign cmd_if.cmd_rdy = cmd_rdy_q;

    // ---------------------------------------------------------------- TX
    tx_state_t        tx_state, tx_next;
    logic [9:0]       tx_frame;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bits;
    logic             resp_sent_q;
    logic             tx_load, tx_tick, tx_done;

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            TX_IDLE:  if (cmd_if.snd_resp) tx_next = TX_SHIFT;
            TX_SHIFT: if (tx_done) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_load = (tx_state == TX_IDLE) && cmd_if.snd_resp;
        tx_tick = (tx_state == TX_SHIFT) && (tx_cnt == FULL);
        tx_done = tx_tick && (tx_bits == 4'd9);
    end

    // Shift register back-fills with 1s, so it is all-ones (line idle) once a
    // frame has fully drained and TX can come straight from bit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_frame    <= '1;
            tx_cnt      <= '0;
            tx_bits     <= '0;
            resp_sent_q <= 1'b0;
        end else if (tx_load) begin
            tx_frame    <= {1'b1, cmd_if.resp, 1'b0};
            tx_cnt      <= '0;
            tx_bits     <= '0;
            resp_sent_q <= 1'b0;
        end else if (tx_tick) begin
            tx_frame <= {1'b1, tx_frame[9:1]};
            tx_cnt   <= '0;
            tx_bits  <= tx_done ? 4'd0 : tx_bits + 4'd1;
            if (tx_done) resp_sent_q <= 1'b1;
        end else if (tx_state == TX_SHIFT) begin
            tx_cnt <= tx_cnt + CNT_W'(1);
        end
    end

    assign TX               = tx_frame[0];
    assign cmd_if.resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder at BAUD_DIV=16: directed scenarios plus
// randomized RX/TX traffic checked against a byte-level command model.
module tb_uart_cmd_responder;

    localparam int unsigned BAUD = 16;

    logic clk = 1'b0;
    logic rst;
    logic RX;
    logic TX;

    uart_cmd_responder_if bus();

    uart_cmd_responder #(.BAUD_DIV(BAUD)) dut (
        .clk    (clk),
        .rst    (rst),
        .RX     (RX),
        .TX     (TX),
        .cmd_if (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Counts rising edges of cmd_rdy, observed mid-cycle
    int   rdy_rises = 0;
    logic rdy_seen  = 1'b0;
    always @(negedge clk) begin
        if (bus.cmd_rdy && !rdy_seen) rdy_rises++;
        rdy_seen = bus.cmd_rdy;
    end

    task automatic rx_bit(input logic b);
        RX = b;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(d[i]);
        rx_bit(stop);
        RX = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        RX = 1'b1;
        bus.clr_cmd_rdy = 1'b0;
        bus.snd_resp = 1'b0;
        bus.resp = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", TX); end
        checks++; if (bus.cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd: got %h want 0000", bus.cmd); end
        checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy: got %b want 0", bus.cmd_rdy); end
        checks++; if (bus.resp_sent !== 1'b0) begin errors++; $display("FAIL reset_resp_sent: got %b want 0", bus.resp_sent); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_cmd_basic;
        logic [7:0] b = 8'hF1;
        send_byte(8'h23, 1'b1);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        RX = 1'b1;
        @(negedge clk);
        checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL basic_early_rdy: got %b want 0", bus.cmd_rdy); end
        repeat (BAUD + 1) @(negedge clk);
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy: got %b want 1", bus.cmd_rdy); end
        checks++; if (bus.cmd !== 16'h23F1) begin errors++; $display("FAIL basic_cmd: got %h want 23f1", bus.cmd); end
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL basic_clr: got %b want 0", bus.cmd_rdy); end
        checks++; if (bus.cmd !== 16'h23F1) begin errors++; $display("FAIL basic_cmd_hold: got %h want 23f1", bus.cmd); end
    endtask

    task automatic test_resp;
        logic       exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [9:0] bad = '0;
        bus.resp = 8'hA5;
        bus.snd_resp = 1'b1;
        @(negedge clk);
        bus.snd_resp = 1'b0;
        for (int k = 0; k < 160; k++) begin
            if (TX !== exp_bits[k / 16]) bad[k / 16] = 1'b1;
            if (k == 159) begin
                checks++; if (bus.resp_sent !== 1'b0) begin errors++; $display("FAIL resp_sent_early: got %b want 0", bus.resp_sent); end
            end
            if (k == 70) begin bus.snd_resp = 1'b1; bus.resp = 8'h3C; end
            if (k == 71) begin bus.snd_resp = 1'b0; bus.resp = 8'hA5; end
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            checks++; if (bad[i]) begin errors++; $display("FAIL resp_bit%0d: TX deviated from %b during bit", i, exp_bits[i]); end
        end
        checks++; if (bus.resp_sent !== 1'b1) begin errors++; $display("FAIL resp_sent: got %b want 1", bus.resp_sent); end
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL resp_idle_tx: got %b want 1", TX); end
        repeat (40) @(negedge clk);
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL resp_no_retx: got %b want 1", TX); end
    endtask

    task automatic test_set_wins;
        logic [9:0] frame = {1'b1, 8'h44, 1'b0};
        int ones = 0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL sw_pre_rdy: got %b want 1", bus.cmd_rdy); end
        RX = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL sw_start_clears: got %b want 0", bus.cmd_rdy); end
        repeat (BAUD - 5) @(negedge clk);
        begin
            logic [7:0] d = 8'h33;
            for (int i = 0; i < 8; i++) rx_bit(d[i]);
        end
        rx_bit(1'b1);
        repeat (4) @(negedge clk);
        bus.clr_cmd_rdy = 1'b1;
        for (int i = 0; i < 10 * BAUD + 4; i++) begin
            RX = (i < 10 * BAUD) ? frame[i / BAUD] : 1'b1;
            @(negedge clk);
            if (bus.cmd_rdy === 1'b1) ones++;
        end
        bus.clr_cmd_rdy = 1'b0;
        checks++; if (ones != 1) begin errors++; $display("FAIL sw_set_wins: cmd_rdy high %0d cycles, want 1", ones); end
        checks++; if (bus.cmd !== 16'h3344) begin errors++; $display("FAIL sw_cmd: got %h want 3344", bus.cmd); end
    endtask

    task automatic test_framing;
        int start_rises = rdy_rises;
        send_byte(8'h00, 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b0);
        send_byte(8'h00, 1'b1);
        checks++; if (bus.cmd !== 16'h3344) begin errors++; $display("FAIL frm_cmd_hold: got %h want 3344", bus.cmd); end
        send_byte(8'h00, 1'b1);
        checks++; if (rdy_rises - start_rises != 1) begin errors++; $display("FAIL frm_rdy_count: got %0d want 1", rdy_rises - start_rises); end
        checks++; if (bus.cmd !== 16'h0000) begin errors++; $display("FAIL frm_cmd: got %h want 0000", bus.cmd); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL frm_rdy: got %b want 1", bus.cmd_rdy); end
    endtask

    task automatic test_glitch_reset;
        logic [9:0] frame = {1'b1, 8'h96, 1'b0};
        send_byte(8'h5A, 1'b1);
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        send_byte(8'hC3, 1'b1);
        checks++; if (bus.cmd !== 16'h5AC3) begin errors++; $display("FAIL glitch_cmd: got %h want 5ac3", bus.cmd); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL glitch_rdy: got %b want 1", bus.cmd_rdy); end
        send_byte(8'h77, 1'b1);
        for (int n = 0; n < 88; n++) begin
            RX = frame[n / BAUD];
            if (n == 48) begin bus.resp = 8'h00; bus.snd_resp = 1'b1; end
            if (n == 49) bus.snd_resp = 1'b0;
            @(negedge clk);
        end
        checks++; if (TX !== 1'b0) begin errors++; $display("FAIL rst_pre_tx: got %b want 0", TX); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", TX); end
        checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %b want 0", bus.cmd_rdy); end
        checks++; if (bus.cmd !== 16'h0000) begin errors++; $display("FAIL rst_cmd: got %h want 0000", bus.cmd); end
        rst = 1'b0;
        RX = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL rst_tx_idle: got %b want 1", TX); end
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        checks++; if (bus.cmd !== 16'hBEEF) begin errors++; $display("FAIL rst_next_cmd: got %h want beef", bus.cmd); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL rst_next_rdy: got %b want 1", bus.cmd_rdy); end
    endtask

    task automatic test_duplex;
        logic [9:0] bad = '0;
        logic [7:0] r = 8'hA5;
        fork
            begin
                send_byte(8'h12, 1'b1);
                send_byte(8'h34, 1'b1);
            end
            begin
                repeat (20) @(negedge clk);
                bus.resp = r;
                bus.snd_resp = 1'b1;
                @(negedge clk);
                bus.snd_resp = 1'b0;
                for (int k = 0; k < 160; k++) begin
                    int  bi = k / 16;
                    logic e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : r[bi - 1];
                    if (TX !== e) bad[bi] = 1'b1;
                    @(negedge clk);
                end
            end
        join
        checks++; if (bad != 10'd0) begin errors++; $display("FAIL duplex_tx: bad bit mask %b want 0000000000", bad); end
        checks++; if (bus.resp_sent !== 1'b1) begin errors++; $display("FAIL duplex_resp_sent: got %b want 1", bus.resp_sent); end
        checks++; if (bus.cmd !== 16'h1234) begin errors++; $display("FAIL duplex_cmd: got %h want 1234", bus.cmd); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL duplex_rdy: got %b want 1", bus.cmd_rdy); end
    endtask

    // Model: good bytes pair up high-then-low; a bad stop bit discards any
    // pending high byte; a frame starting with no pending byte clears ready.
    task automatic test_random_cmds;
        logic [15:0] m_cmd = bus.cmd;
        logic        m_rdy = 1'b0;
        logic        m_pending = 1'b0;
        logic [7:0]  m_hi = 8'h00;
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        for (int n = 0; n < 12; n++) begin
            logic [7:0] d  = 8'($urandom_range(0, 255));
            logic       ok = ($urandom_range(0, 3) != 0);
            if (!m_pending) m_rdy = 1'b0;
            send_byte(d, ok);
            if (!ok) begin
                m_pending = 1'b0;
            end else if (m_pending) begin
                m_cmd = {m_hi, d};
                m_rdy = 1'b1;
                m_pending = 1'b0;
            end else begin
                m_hi = d;
                m_pending = 1'b1;
            end
            checks++; if (bus.cmd_rdy !== m_rdy) begin errors++; $display("FAIL rand_rdy[%0d]: got %b want %b", n, bus.cmd_rdy, m_rdy); end
            checks++; if (bus.cmd !== m_cmd) begin errors++; $display("FAIL rand_cmd[%0d]: got %h want %h", n, bus.cmd, m_cmd); end
        end
    endtask

    task automatic test_random_resp;
        for (int n = 0; n < 3; n++) begin
            logic [7:0] r = 8'($urandom_range(0, 255));
            logic [9:0] bad = '0;
            bus.resp = r;
            bus.snd_resp = 1'b1;
            @(negedge clk);
            bus.snd_resp = 1'b0;
            checks++; if (bus.resp_sent !== 1'b0) begin errors++; $display("FAIL rresp_clear[%0d]: got %b want 0", n, bus.resp_sent); end
            for (int k = 0; k < 160; k++) begin
                int   bi = k / 16;
                logic e  = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : r[bi - 1];
                if (TX !== e) bad[bi] = 1'b1;
                @(negedge clk);
            end
            checks++; if (bad != 10'd0) begin errors++; $display("FAIL rresp_tx[%0d]: resp %h bad bit mask %b want 0000000000", n, r, bad); end
            checks++; if (bus.resp_sent !== 1'b1) begin errors++; $display("FAIL rresp_sent[%0d]: got %b want 1", n, bus.resp_sent); end
            repeat (5) @(negedge clk);
        end
    endtask

    initial begin
        RX = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_cmd_basic();
        test_resp();
        test_set_wins();
        test_framing();
        test_glitch_reset();
        test_duplex();
        test_random_cmds();
        test_random_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
